// File: rtl/adrdec_prog_pkg.sv
// Shared definitions for the programmable address-region decoder.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Holds the attribute bit layout, the config-field encodings and the
// attribute-permission helper used by every region slice.
package adrdec_prog_pkg;

    // Attribute bit positions inside the 10-bit per-region attribute word.
    localparam int ATTR_EN    = 0;
    localparam int ATTR_R     = 1;
    localparam int ATTR_W     = 2;
    localparam int ATTR_X     = 3;
    localparam int ATTR_C     = 4;
    localparam int ATTR_SZ_LO = 5;   // SizeMask occupies [8:5]; bit 5+n permits Size n
    localparam int ATTR_SZ_HI = 8;
    localparam int ATTR_LOCK  = 9;
    localparam int ATTR_BITS  = 10;

    localparam logic [7:0] FAULT_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CFG_BASE  = 2'd0,
        CFG_RANGE = 2'd1,
        CFG_ATTR  = 2'd2,
        CFG_RSVD  = 2'd3
    } cfg_field_e;

    // Packed MSB-first, so the layout matches the ATTR_* positions above.
    typedef struct packed {
        logic       lock;        // [9]
        logic [3:0] size_mask;   // [8:5]
        logic       c;           // [4]
        logic       x;           // [3]
        logic       w;           // [2]
        logic       r;           // [1]
        logic       en;          // [0]
    } adrdec_attr_t;

    // True when every requested access kind is granted and the access size
    // is enabled in the region's SizeMask.
    function automatic logic attr_permits(
        input adrdec_attr_t a,
        input logic         acc_r,
        input logic         acc_w,
        input logic         acc_x,
        input logic         acc_c,
        input logic [1:0]   size
    );
        return (!acc_r || a.r) && (!acc_w || a.w) && (!acc_x || a.x) &&
               (!acc_c || a.c) && a.size_mask[size];
    endfunction

endpackage

// File: rtl/adrdec_prog_region.sv
// One programmable region: base/range/attr registers, write+lock, match/permit.
// Latency: config write lands on the next edge; match/permit are combinational.
// Backpressure: none; rejected writes are flagged combinationally via wr_bad.
//
// Ports:
//   clk, rst_n            clock, async active-low reset (clears all state)
//   wr_sel                write strobe already qualified with this region's index
//   wr_field, wr_data     field selector and data of the config write
//   wr_bad                write addressed here would be rejected (lock/reserved/bad range)
//   addr, acc_*, size     lookup request
//   match, permit         region hit, and whether the requested access is allowed
module adrdec_prog_region
    import adrdec_prog_pkg::*;
#(
    parameter int PA_BITS = 34
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_sel,
    input  logic [1:0]         wr_field,
    input  logic [PA_BITS-1:0] wr_data,
    output logic               wr_bad,
    input  logic [PA_BITS-1:0] addr,
    input  logic               acc_r,
    input  logic               acc_w,
    input  logic               acc_x,
    input  logic               acc_c,
    input  logic [1:0]         size,
    output logic               match,
    output logic               permit
);

    logic [PA_BITS-1:0] base_q;
    logic [PA_BITS-1:0] range_q;
    adrdec_attr_t       attr_q;

    cfg_field_e field;
    logic       range_ok;

    assign field = cfg_field_e'(wr_field);

    // A legal range is 2^k-1: a run of ones from bit 0. Adding one carries
    // through exactly that run, so the AND is zero only for such values
    // (all-ones wraps to zero and is legal: the whole address space).
    assign range_ok = ((wr_data + PA_BITS'(1)) & wr_data) == '0;

    assign wr_bad = wr_sel &&
                    (attr_q.lock ||
                     field == CFG_RSVD ||
                     (field == CFG_RANGE && !range_ok));

    // Lock has no clear path other than reset: once set, wr_bad blocks
    // every further write, including to the attribute word itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q  <= '0;
            range_q <= '0;
            attr_q  <= '0;
        end else if (wr_sel && !wr_bad) begin
            case (field)
                CFG_BASE:  base_q  <= wr_data;
                CFG_RANGE: range_q <= wr_data;
                CFG_ATTR:  attr_q  <= adrdec_attr_t'(wr_data[ATTR_BITS-1:0]);
                default:   ;
            endcase
        end
    end

    assign match  = attr_q.en && ((addr & ~range_q) == (base_q & ~range_q));
    assign permit = attr_permits(attr_q, acc_r, acc_w, acc_x, acc_c, size);

endmodule

// File: rtl/adrdec_prog.sv
// Runtime-programmable physical-address region decoder with fault capture.
// Latency: 1 cycle from request to registered select/fault; CfgErr 1 cycle after write.
// Backpressure: none; accepts one request and one config write every cycle.
//
// Ports:
//   HCLK, HRESETn                       clock, async active-low reset
//   CfgWrEn/CfgIdx/CfgField/CfgWData    region config write; CfgErr pulses on rejection
//   ReqValid/PhysicalAddress/Access*/Size  lookup request
//   RespValid/SelRegions/RespFault      registered response; SelRegions[0] = no match
//   FaultValid/FaultAddr/FaultCount     first-fault record and saturating count
//   FaultClear                          clears the fault record
module adrdec_prog
    import adrdec_prog_pkg::*;
#(
    parameter int PA_BITS  = 34,
    parameter int NREGIONS = 16,
    parameter int IDX_W    = (NREGIONS > 1) ? $clog2(NREGIONS) : 1
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                CfgWrEn,
    input  logic [IDX_W-1:0]    CfgIdx,
    input  logic [1:0]          CfgField,
    input  logic [PA_BITS-1:0]  CfgWData,
    output logic                CfgErr,
    input  logic                ReqValid,
    input  logic [PA_BITS-1:0]  PhysicalAddress,
    input  logic                AccessR,
    input  logic                AccessW,
    input  logic                AccessX,
    input  logic                AccessC,
    input  logic [1:0]          Size,
    output logic                RespValid,
    output logic [NREGIONS:0]   SelRegions,
    output logic                RespFault,
    output logic                FaultValid,
    output logic [PA_BITS-1:0]  FaultAddr,
    output logic [7:0]          FaultCount,
    input  logic                FaultClear
);

    localparam int IDX_W1 = IDX_W + 1;

    logic [NREGIONS-1:0] reg_wr_sel;
    logic [NREGIONS-1:0] reg_wr_bad;
    logic [NREGIONS-1:0] reg_match;
    logic [NREGIONS-1:0] reg_permit;
    logic [NREGIONS-1:0] first_hit;
    logic [NREGIONS:0]   sel_d;
    logic                fault_d;
    logic                idx_bad;
    logic                cfg_err_d;
    logic                new_fault;

    // Index space may be wider than the region count (non power-of-two NREGIONS).
    assign idx_bad = {1'b0, CfgIdx} >= IDX_W1'(NREGIONS);

    for (genvar i = 0; i < NREGIONS; i++) begin : g_region
        assign reg_wr_sel[i] = CfgWrEn && (CfgIdx == IDX_W'(i));

        adrdec_prog_region #(
            .PA_BITS (PA_BITS)
        ) u_region (
            .clk      (HCLK),
            .rst_n    (HRESETn),
            .wr_sel   (reg_wr_sel[i]),
            .wr_field (CfgField),
            .wr_data  (CfgWData),
            .wr_bad   (reg_wr_bad[i]),
            .addr     (PhysicalAddress),
            .acc_r    (AccessR),
            .acc_w    (AccessW),
            .acc_x    (AccessX),
            .acc_c    (AccessC),
            .size     (Size),
            .match    (reg_match[i]),
            .permit   (reg_permit[i])
        );
    end

    // Isolate the lowest set match bit: two's complement leaves only the
    // least-significant one in common with the original vector.
    assign first_hit = reg_match & (~reg_match + NREGIONS'(1));
    assign sel_d     = {first_hit, ~|reg_match};

    // With no match first_hit is zero, so the AND is zero and the access
    // faults; otherwise only the winning region's permission counts.
    assign fault_d   = ~|(first_hit & reg_permit);

    assign cfg_err_d = CfgWrEn && (idx_bad || (|reg_wr_bad));
    assign new_fault = ReqValid && fault_d;

    // Response and config-error registers. Select and fault are forced to
    // zero on idle cycles so consumers can OR them without qualifying.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            RespValid  <= 1'b0;
            SelRegions <= '0;
            RespFault  <= 1'b0;
            CfgErr     <= 1'b0;
        end else begin
            RespValid  <= ReqValid;
            SelRegions <= ReqValid ? sel_d : '0;
            RespFault  <= new_fault;
            CfgErr     <= cfg_err_d;
        end
    end

    // Fault record. A clear coinciding with a new fault behaves as if the
    // clear happened first, so the new fault becomes the first one.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            FaultValid <= 1'b0;
            FaultAddr  <= '0;
            FaultCount <= '0;
        end else if (new_fault && (!FaultValid || FaultClear)) begin
            FaultValid <= 1'b1;
            FaultAddr  <= PhysicalAddress;
            FaultCount <= 8'd1;
        end else if (new_fault) begin
            if (FaultCount != FAULT_CNT_MAX) begin
                FaultCount <= FaultCount + 8'd1;
            end
        end else if (FaultClear) begin
            FaultValid <= 1'b0;
            FaultCount <= '0;
        end
    end

endmodule

// File: tb/tb_adrdec_prog.sv
// Directed bench for adrdec_prog with an array-based reference model.
// Inputs change on the falling edge, both DUT and model sample on the rising
// edge, and every output is compared against the model on the next falling edge.
module tb_adrdec_prog;

    localparam int PA = 34;
    localparam int NR = 16;
    localparam int IW = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic          CfgWrEn;
    logic [IW-1:0] CfgIdx;
    logic [1:0]    CfgField;
    logic [PA-1:0] CfgWData;
    logic          CfgErr;
    logic          ReqValid;
    logic [PA-1:0] PhysicalAddress;
    logic          AccessR, AccessW, AccessX, AccessC;
    logic [1:0]    Size;
    logic          RespValid;
    logic [NR:0]   SelRegions;
    logic          RespFault;
    logic          FaultValid;
    logic [PA-1:0] FaultAddr;
    logic [7:0]    FaultCount;
    logic          FaultClear;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    adrdec_prog #(.PA_BITS(PA), .NREGIONS(NR)) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .CfgWrEn         (CfgWrEn),
        .CfgIdx          (CfgIdx),
        .CfgField        (CfgField),
        .CfgWData        (CfgWData),
        .CfgErr          (CfgErr),
        .ReqValid        (ReqValid),
        .PhysicalAddress (PhysicalAddress),
        .AccessR         (AccessR),
        .AccessW         (AccessW),
        .AccessX         (AccessX),
        .AccessC         (AccessC),
        .Size            (Size),
        .RespValid       (RespValid),
        .SelRegions      (SelRegions),
        .RespFault       (RespFault),
        .FaultValid      (FaultValid),
        .FaultAddr       (FaultAddr),
        .FaultCount      (FaultCount),
        .FaultClear      (FaultClear)
    );

    // ---------------- reference model ----------------
    logic [PA-1:0] m_base  [NR];
    logic [PA-1:0] m_range [NR];
    logic [9:0]    m_attr  [NR];
    int            m_hit;
    logic          m_ok;
    logic          m_pow;
    logic          e_rv, e_flt, e_cfgerr, e_fv;
    logic [NR:0]   e_sel;
    logic [PA-1:0] e_fa;
    int            e_fc;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NR; i++) begin
                m_base[i]  = '0;
                m_range[i] = '0;
                m_attr[i]  = '0;
            end
            e_rv = 0; e_sel = '0; e_flt = 0; e_cfgerr = 0;
            e_fv = 0; e_fa = '0; e_fc = 0;
        end else begin
            // lookup against the state before this edge's write
            m_hit = -1;
            for (int i = NR - 1; i >= 0; i--)
                if (m_attr[i][0] && ((PhysicalAddress & ~m_range[i]) == (m_base[i] & ~m_range[i])))
                    m_hit = i;
            e_rv  = ReqValid;
            e_sel = '0;
            e_flt = 0;
            if (ReqValid) begin
                if (m_hit < 0) begin
                    e_sel[0] = 1'b1;
                    e_flt    = 1'b1;
                end else begin
                    e_sel[m_hit + 1] = 1'b1;
                    e_flt = (AccessR && !m_attr[m_hit][1]) || (AccessW && !m_attr[m_hit][2]) ||
                            (AccessX && !m_attr[m_hit][3]) || (AccessC && !m_attr[m_hit][4]) ||
                            !m_attr[m_hit][5 + int'(Size)];
                end
            end
            if (e_rv && e_flt) begin
                if (!e_fv || FaultClear) begin
                    e_fv = 1; e_fa = PhysicalAddress; e_fc = 1;
                end else if (e_fc < 255) begin
                    e_fc = e_fc + 1;
                end
            end else if (FaultClear) begin
                e_fv = 0; e_fc = 0;
            end
            // config write
            m_pow = 0;
            for (int k = 0; k <= PA; k++)
                if (64'(CfgWData) == ((64'(1) << k) - 64'(1))) m_pow = 1;
            m_ok = CfgWrEn && (int'(CfgIdx) < NR) && (CfgField != 2'd3) &&
                   !m_attr[CfgIdx][9] && (CfgField != 2'd1 || m_pow);
            e_cfgerr = CfgWrEn && !m_ok;
            if (m_ok) begin
                case (CfgField)
                    2'd0:    m_base[CfgIdx]  = CfgWData;
                    2'd1:    m_range[CfgIdx] = CfgWData;
                    default: m_attr[CfgIdx]  = CfgWData[9:0];
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("resp_valid",  64'(RespValid),  64'(e_rv));
        check("sel_regions", 64'(SelRegions), 64'(e_sel));
        check("resp_fault",  64'(RespFault),  64'(e_flt));
        check("cfg_err",     64'(CfgErr),     64'(e_cfgerr));
        check("fault_valid", 64'(FaultValid), 64'(e_fv));
        check("fault_addr",  64'(FaultAddr),  64'(e_fa));
        check("fault_count", 64'(FaultCount), 64'(e_fc));
    endtask

    // ---------------- stimulus ----------------
    task automatic idle();
        CfgWrEn = 0; CfgIdx = '0; CfgField = '0; CfgWData = '0;
        ReqValid = 0; PhysicalAddress = '0;
        AccessR = 0; AccessW = 0; AccessX = 0; AccessC = 0; Size = '0;
        FaultClear = 0;
    endtask

    task automatic step();
        @(posedge HCLK);
        @(negedge HCLK);
        compare_all();
    endtask

    task automatic cfg(input logic [IW-1:0] idx, input logic [1:0] fld, input logic [PA-1:0] d);
        idle();
        CfgWrEn = 1; CfgIdx = idx; CfgField = fld; CfgWData = d;
        step();
        idle();
    endtask

    task automatic req(input logic [PA-1:0] a, input logic r, input logic w,
                       input logic x, input logic c, input logic [1:0] sz);
        idle();
        ReqValid = 1; PhysicalAddress = a;
        AccessR = r; AccessW = w; AccessX = x; AccessC = c; Size = sz;
        step();
        idle();
    endtask

    initial begin
        idle();
        HRESETn = 0;
        repeat (2) @(negedge HCLK);
        check("rst_resp_valid",  64'(RespValid),  64'h0);
        check("rst_sel",         64'(SelRegions), 64'h0);
        check("rst_fault_valid", 64'(FaultValid), 64'h0);
        check("rst_fault_count", 64'(FaultCount), 64'h0);
        check("rst_cfg_err",     64'(CfgErr),     64'h0);
        HRESETn = 1;
        step();

        // nothing programmed: every access misses and faults
        req(34'h0_8000_0000, 1, 0, 0, 0, 2);
        check("miss_sel",   64'(SelRegions), 64'h1);
        check("miss_fault", 64'(RespFault),  64'h1);
        check("miss_fv",    64'(FaultValid), 64'h1);
        check("miss_fa",    64'(FaultAddr),  64'h8000_0000);
        check("miss_fc",    64'(FaultCount), 64'h1);

        // region 3: 4 KiB at 0x1000_0000, En|R|W, SizeMask 0100
        cfg(4'd3, 2'd0, 34'h0_1000_0000);
        cfg(4'd3, 2'd1, 34'h0_0000_0FFF);
        cfg(4'd3, 2'd2, 34'h0_0000_0087);
        req(34'h0_1000_0FFC, 1, 0, 0, 0, 2);
        check("r3_sel",     64'(SelRegions), 64'h10);
        check("r3_fault",   64'(RespFault),  64'h0);
        req(34'h0_1000_0FFC, 1, 0, 0, 0, 3);
        check("r3_sz3",     64'(RespFault),  64'h1);
        req(34'h0_1000_0FFC, 0, 0, 1, 0, 2);
        check("r3_exec",    64'(RespFault),  64'h1);
        req(34'h0_1000_0FFC, 1, 0, 0, 1, 2);
        check("r3_cache",   64'(RespFault),  64'h1);
        req(34'h0_1000_1000, 1, 0, 0, 0, 2);
        check("r3_edge",    64'(SelRegions), 64'h1);

        // overlapping regions 1 and 5, lowest index wins
        cfg(4'd1, 2'd0, 34'h0_2000_0000);
        cfg(4'd1, 2'd1, 34'h0_0000_FFFF);
        cfg(4'd1, 2'd2, 34'h0_0000_01E3);
        cfg(4'd5, 2'd0, 34'h0_2000_0000);
        cfg(4'd5, 2'd1, 34'h0_000F_FFFF);
        cfg(4'd5, 2'd2, 34'h0_0000_01E3);
        req(34'h0_2000_0010, 1, 0, 0, 0, 0);
        check("ovl_sel",    64'(SelRegions), 64'h4);
        cfg(4'd1, 2'd2, 34'h0_0000_01E2);
        req(34'h0_2000_0010, 1, 0, 0, 0, 0);
        check("ovl_dis",    64'(SelRegions), 64'h40);

        // lock region 0 and check writes bounce
        cfg(4'd0, 2'd1, 34'h0_0000_0FFF);
        cfg(4'd0, 2'd2, 34'h0_0000_03E3);
        check("lock_ok",    64'(CfgErr),     64'h0);
        cfg(4'd0, 2'd0, 34'h0_3000_0000);
        check("lock_err",   64'(CfgErr),     64'h1);
        step();
        check("lock_pulse", 64'(CfgErr),     64'h0);
        req(34'h0_0000_0100, 1, 0, 0, 0, 2);
        check("lock_base",  64'(SelRegions), 64'h2);
        cfg(4'd0, 2'd2, 34'h0_0000_01E3);
        check("lock_attr",  64'(CfgErr),     64'h1);
        cfg(4'd2, 2'd1, 34'h0_0000_1001);
        check("bad_range",  64'(CfgErr),     64'h1);
        cfg(4'd2, 2'd3, 34'h0_0000_0005);
        check("rsvd_field", 64'(CfgErr),     64'h1);
        cfg(4'd2, 2'd1, 34'h3_FFFF_FFFF);
        check("full_range", 64'(CfgErr),     64'h0);

        // fault counter saturation
        FaultClear = 1;
        step();
        idle();
        check("clr_fv",     64'(FaultValid), 64'h0);
        check("clr_fc",     64'(FaultCount), 64'h0);
        for (int i = 0; i < 300; i++)
            req(34'h0_9000_0000 + 34'(4 * i), 1, 0, 0, 0, 2);
        check("sat_fc",     64'(FaultCount), 64'd255);
        check("sat_fa",     64'(FaultAddr),  64'h9000_0000);
        FaultClear = 1; ReqValid = 1; PhysicalAddress = 34'h0_A000_0000; AccessR = 1; Size = 2;
        step();
        idle();
        check("clrf_fc",    64'(FaultCount), 64'h1);
        check("clrf_fa",    64'(FaultAddr),  64'hA000_0000);

        // base write and request together: request sees the old base
        CfgWrEn = 1; CfgIdx = 4'd3; CfgField = 2'd0; CfgWData = 34'h0_1100_0000;
        ReqValid = 1; PhysicalAddress = 34'h0_1000_0000; AccessR = 1; Size = 2;
        step();
        idle();
        check("same_old",   64'(SelRegions), 64'h10);
        req(34'h0_1000_0000, 1, 0, 0, 0, 2);
        check("same_gone",  64'(SelRegions), 64'h1);
        req(34'h0_1100_0004, 1, 0, 0, 0, 2);
        check("same_new",   64'(SelRegions), 64'h10);

        // reset between request and response
        ReqValid = 1; PhysicalAddress = 34'h0_1100_0004; AccessR = 1; Size = 2;
        @(posedge HCLK);
        #1 HRESETn = 0;
        @(negedge HCLK);
        compare_all();
        check("mid_rst_rv",  64'(RespValid),  64'h0);
        check("mid_rst_sel", 64'(SelRegions), 64'h0);
        idle();
        HRESETn = 1;
        step();
        req(34'h0_1100_0004, 1, 0, 0, 0, 2);
        check("post_rst",    64'(SelRegions), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
